// File: rtl/uart_out_tx.sv
// Output half of the CPU serial path: byte FIFO fed by the OUT instruction,
// drained by an 8N1 transmitter. Stalls the CPU when a request does not fit.
module uart_out_tx #(
    parameter int unsigned CLK_PER_BIT = 868,
    parameter int unsigned LOG2_DEPTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  out_valid,
    input  logic                  out_word,
    input  logic [31:0]           outw,
    output logic                  out_stall,
    output logic                  txd,
    output logic                  tx_busy,
    output logic                  tx_drained,
    output logic [LOG2_DEPTH:0]   fifo_count
);

    localparam int unsigned         DEPTH     = 1 << LOG2_DEPTH;
    localparam int unsigned         BAUD_W    = $clog2(CLK_PER_BIT);
    localparam logic [BAUD_W-1:0]   BAUD_LAST = BAUD_W'(CLK_PER_BIT - 1);
    localparam logic [LOG2_DEPTH:0] DEPTH_C   = (LOG2_DEPTH + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]            mem_q [DEPTH];
    logic [LOG2_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [LOG2_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [LOG2_DEPTH:0]   count_q, count_d;
    logic [LOG2_DEPTH:0]   need, free_space;
    logic                  accept, pop;

    state_t                state_q, state_d;
    logic [BAUD_W-1:0]     baud_q, baud_d;
    logic [2:0]            bit_q, bit_d;
    logic [7:0]            shift_q, shift_d;
    logic                  txd_q, txd_d;

    // Free space is judged on the registered count only; a same-cycle pop does not help.
    assign need       = out_word ? (LOG2_DEPTH + 1)'(4) : (LOG2_DEPTH + 1)'(1);
    assign free_space = DEPTH_C - count_q;
    assign out_stall  = out_valid & (free_space < need);
    assign accept     = out_valid & ~out_stall;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        if (accept) begin
            wr_ptr_d = wr_ptr_q + (out_word ? LOG2_DEPTH'(4) : LOG2_DEPTH'(1));
        end
        rd_ptr_d = pop ? rd_ptr_q + LOG2_DEPTH'(1) : rd_ptr_q;
        count_d  = count_q + (accept ? need : '0) - (pop ? (LOG2_DEPTH + 1)'(1) : '0);
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= outw[7:0];
            if (out_word) begin
                for (int unsigned k = 1; k < 4; k++) begin
                    mem_q[wr_ptr_q + LOG2_DEPTH'(k)] <= outw[8*k +: 8];
                end
            end
        end
    end

    // txd is registered from the next state so the line changes together with the state.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    baud_d  = '0;
                    state_d = START;
                    txd_d   = 1'b0;
                end
            end
            START: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                    txd_d   = shift_q[0];
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        txd_d = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        state_d = START;
                        txd_d   = 1'b0;
                    end else begin
                        state_d = IDLE;
                        txd_d   = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            txd_q    <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            txd_q    <= txd_d;
        end
    end

    assign txd        = txd_q;
    assign tx_busy    = (state_q != IDLE);
    assign tx_drained = (count_q == '0) && (state_q == IDLE);
    assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_out_tx.sv
// Directed bench for uart_out_tx at CLK_PER_BIT=4, depth 8; a line monitor
// decodes 8N1 frames from txd for ordering and back-to-back checks.
module tb_uart_out_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        out_valid;
    logic        out_word;
    logic [31:0] outw;
    logic        out_stall;
    logic        txd;
    logic        tx_busy;
    logic        tx_drained;
    logic [3:0]  fifo_count;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic [7:0]  rx_q[$];
    int          rx_t[$];
    int          frame_err = 0;
    bit          mon_en = 1'b0;

    uart_out_tx #(.CLK_PER_BIT(4), .LOG2_DEPTH(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .out_valid  (out_valid),
        .out_word   (out_word),
        .outw       (outw),
        .out_stall  (out_stall),
        .txd        (txd),
        .tx_busy    (tx_busy),
        .tx_drained (tx_drained),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Samples each bit in its middle: start at +2 cycles, bit i at +6+4i, stop at +38.
    initial begin : line_monitor
        logic [7:0] b;
        logic       st, sp;
        int         t0;
        forever begin
            @(negedge clk);
            if (mon_en && txd === 1'b0) begin
                t0 = cyc;
                repeat (2) @(negedge clk);
                st = txd;
                for (int i = 0; i < 8; i++) begin
                    repeat (4) @(negedge clk);
                    b[i] = txd;
                end
                repeat (4) @(negedge clk);
                sp = txd;
                if (st !== 1'b0 || sp !== 1'b1) frame_err++;
                rx_q.push_back(b);
                rx_t.push_back(t0);
            end
        end
    end

    task automatic wait_rx(input int n, input int budget, input string name);
        int w = 0;
        while (rx_q.size() < n && w < budget) begin
            @(negedge clk);
            w++;
        end
        n_cmp++;
        if (rx_q.size() !== n) begin
            n_err++;
            $display("FAIL %s rx_count: got %0d expected %0d", name, rx_q.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; out_valid = 1'b0; out_word = 1'b0; outw = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            n_cmp++;
            if ({txd, tx_drained, tx_busy, out_stall, fifo_count} !== {4'b1100, 4'd0}) begin
                n_err++;
                $display("FAIL reset_idle cyc%0d: got txd=%b drained=%b busy=%b stall=%b cnt=%0d expected 1 1 0 0 0",
                         i, txd, tx_drained, tx_busy, out_stall, fifo_count);
            end
        end
    endtask

    task automatic test_single_byte();
        logic [7:0] bv = 8'hA5;
        logic       exp_txd;
        rx_q.delete(); rx_t.delete();
        @(negedge clk);
        out_valid = 1'b1; out_word = 1'b0; outw = 32'h0000_00A5; #1;
        n_cmp++;
        if (out_stall !== 1'b0) begin
            n_err++; $display("FAIL single_stall: got %b expected 0", out_stall);
        end
        @(negedge clk);
        out_valid = 1'b0; #1;
        n_cmp++;
        if (fifo_count !== 4'd1 || txd !== 1'b1) begin
            n_err++; $display("FAIL single_push: got cnt=%0d txd=%b expected cnt=1 txd=1", fifo_count, txd);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (fifo_count !== 4'd0) begin
            n_err++; $display("FAIL single_pop: got cnt=%0d expected 0", fifo_count);
        end
        for (int j = 0; j < 40; j++) begin
            if (j > 0) begin @(negedge clk); #1; end
            if (j < 4)       exp_txd = 1'b0;
            else if (j < 36) exp_txd = bv[(j - 4) / 4];
            else             exp_txd = 1'b1;
            n_cmp++;
            if (txd !== exp_txd || tx_busy !== 1'b1 || tx_drained !== 1'b0) begin
                n_err++;
                $display("FAIL single_frame cyc%0d: got txd=%b busy=%b drained=%b expected txd=%b busy=1 drained=0",
                         j, txd, tx_busy, tx_drained, exp_txd);
            end
        end
        @(negedge clk); #1;
        n_cmp++;
        if (tx_drained !== 1'b1 || tx_busy !== 1'b0) begin
            n_err++; $display("FAIL single_drained: got drained=%b busy=%b expected 1 0", tx_drained, tx_busy);
        end
    endtask

    task automatic test_word();
        logic [31:0] w = 32'h4433_2211;
        rx_q.delete(); rx_t.delete();
        @(negedge clk);
        out_valid = 1'b1; out_word = 1'b1; outw = w;
        @(negedge clk);
        out_valid = 1'b0; #1;
        n_cmp++;
        if (fifo_count !== 4'd4) begin
            n_err++; $display("FAIL word_count: got %0d expected 4", fifo_count);
        end
        wait_rx(4, 300, "word");
        for (int k = 0; k < 4 && k < rx_q.size(); k++) begin
            n_cmp++;
            if (rx_q[k] !== w[8*k +: 8]) begin
                n_err++; $display("FAIL word_byte%0d: got %02h expected %02h", k, rx_q[k], w[8*k +: 8]);
            end
            if (k > 0) begin
                n_cmp++;
                if (rx_t[k] - rx_t[k-1] !== 40) begin
                    n_err++; $display("FAIL word_gap%0d: got %0d expected 40", k, rx_t[k] - rx_t[k-1]);
                end
            end
        end
        n_cmp++;
        if (frame_err !== 0) begin
            n_err++; $display("FAIL word_framing: got %0d expected 0", frame_err);
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_full_stall();
        logic [7:0] exp_b [13] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                                   8'hEE, 8'h09, 8'h0A, 8'h0B, 8'h0C};
        int w;
        rx_q.delete(); rx_t.delete();
        @(negedge clk);
        out_valid = 1'b1; out_word = 1'b1; outw = 32'h0403_0201; #1;
        n_cmp++;
        if (out_stall !== 1'b0) begin
            n_err++; $display("FAIL full_first_stall: got %b expected 0", out_stall);
        end
        @(negedge clk);
        outw = 32'h0807_0605; #1;
        n_cmp++;
        if (fifo_count !== 4'd4 || out_stall !== 1'b0) begin
            n_err++; $display("FAIL full_second: got cnt=%0d stall=%b expected 4 0", fifo_count, out_stall);
        end
        @(negedge clk);
        outw = 32'h0C0B_0A09; #1;
        n_cmp++;
        if (fifo_count !== 4'd7 || out_stall !== 1'b1) begin
            n_err++; $display("FAIL full_third: got cnt=%0d stall=%b expected 7 1", fifo_count, out_stall);
        end
        repeat (3) begin
            @(negedge clk); #1;
            n_cmp++;
            if (fifo_count !== 4'd7 || out_stall !== 1'b1) begin
                n_err++; $display("FAIL full_hold: got cnt=%0d stall=%b expected 7 1", fifo_count, out_stall);
            end
        end
        out_word = 1'b0; outw = 32'h0000_00EE; #1;
        n_cmp++;
        if (out_stall !== 1'b0) begin
            n_err++; $display("FAIL full_byte_accept: got stall=%b expected 0", out_stall);
        end
        @(negedge clk);
        out_word = 1'b1; outw = 32'h0C0B_0A09; #1;
        n_cmp++;
        if (fifo_count !== 4'd8 || out_stall !== 1'b1) begin
            n_err++; $display("FAIL full_at_depth: got cnt=%0d stall=%b expected 8 1", fifo_count, out_stall);
        end
        w = 0;
        while (out_stall === 1'b1 && w < 400) begin
            @(negedge clk); #1;
            w++;
        end
        n_cmp++;
        if (out_stall !== 1'b0 || fifo_count !== 4'd4) begin
            n_err++; $display("FAIL full_release: got stall=%b cnt=%0d expected 0 4", out_stall, fifo_count);
        end
        @(negedge clk);
        out_valid = 1'b0; #1;
        n_cmp++;
        if (fifo_count !== 4'd8) begin
            n_err++; $display("FAIL full_refill: got cnt=%0d expected 8", fifo_count);
        end
        wait_rx(13, 800, "full");
        for (int k = 0; k < 13 && k < rx_q.size(); k++) begin
            n_cmp++;
            if (rx_q[k] !== exp_b[k]) begin
                n_err++; $display("FAIL full_order%0d: got %02h expected %02h", k, rx_q[k], exp_b[k]);
            end
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_wrap();
        logic [7:0]  exp_q[$];
        logic [31:0] v;
        logic [3:0]  max_cnt = '0;
        int          w;
        bit          timed_out = 1'b0;
        rx_q.delete(); rx_t.delete();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i % 3 != 1) begin
                out_word = 1'b1;
                v = {8'(4*i + 8'h43), 8'(4*i + 8'h42), 8'(4*i + 8'h41), 8'(4*i + 8'h40)};
            end else begin
                out_word = 1'b0;
                v = 32'hDEAD_BE00 | 32'(8'h80 + i);
            end
            outw = v; out_valid = 1'b1; #1;
            if (fifo_count > max_cnt) max_cnt = fifo_count;
            w = 0;
            while (out_stall === 1'b1 && w < 400) begin
                @(negedge clk); #1;
                if (fifo_count > max_cnt) max_cnt = fifo_count;
                w++;
            end
            if (w >= 400) timed_out = 1'b1;
            exp_q.push_back(v[7:0]);
            if (out_word) begin
                exp_q.push_back(v[15:8]); exp_q.push_back(v[23:16]); exp_q.push_back(v[31:24]);
            end
        end
        @(negedge clk);
        out_valid = 1'b0;
        n_cmp++;
        if (timed_out) begin
            n_err++; $display("FAIL wrap_stall_timeout: got timeout=1 expected 0");
        end
        wait_rx(exp_q.size(), exp_q.size() * 40 + 400, "wrap");
        for (int k = 0; k < exp_q.size() && k < rx_q.size(); k++) begin
            n_cmp++;
            if (rx_q[k] !== exp_q[k]) begin
                n_err++; $display("FAIL wrap_order%0d: got %02h expected %02h", k, rx_q[k], exp_q[k]);
            end
        end
        n_cmp++;
        if (max_cnt > 4'd8) begin
            n_err++; $display("FAIL wrap_max_count: got %0d expected <=8", max_cnt);
        end
        n_cmp++;
        if (frame_err !== 0) begin
            n_err++; $display("FAIL wrap_framing: got %0d expected 0", frame_err);
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        @(negedge clk);
        out_valid = 1'b1; out_word = 1'b1; outw = 32'h3322_1107;
        @(negedge clk);
        out_valid = 1'b0;
        @(negedge clk); #1;
        n_cmp++;
        if (fifo_count !== 4'd3 || tx_busy !== 1'b1) begin
            n_err++; $display("FAIL rstmid_setup: got cnt=%0d busy=%b expected 3 1", fifo_count, tx_busy);
        end
        // 17 cycles after the pop edge lands in the second cycle of data bit 3 (0x07 bit3 = 0).
        repeat (17) @(negedge clk);
        #1;
        n_cmp++;
        if (txd !== 1'b0) begin
            n_err++; $display("FAIL rstmid_bit3: got txd=%b expected 0", txd);
        end
        rst = 1'b1;
        @(negedge clk); #1;
        rst = 1'b0;
        n_cmp++;
        if ({txd, fifo_count, tx_busy, tx_drained, out_stall} !== {1'b1, 4'd0, 3'b010}) begin
            n_err++;
            $display("FAIL rstmid_after: got txd=%b cnt=%0d busy=%b drained=%b stall=%b expected 1 0 0 1 0",
                     txd, fifo_count, tx_busy, tx_drained, out_stall);
        end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            n_cmp++;
            if (txd !== 1'b1 || tx_busy !== 1'b0 || fifo_count !== 4'd0) begin
                n_err++;
                $display("FAIL rstmid_quiet cyc%0d: got txd=%b busy=%b cnt=%0d expected 1 0 0",
                         i, txd, tx_busy, fifo_count);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_word();
        test_full_stall();
        test_wrap();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_out_tx.md
Name: uart_out_tx

Overview:
- Output side of the CPU's serial I/O path; the register file owns the receive side.
- Accepts register values from the CPU's output instruction and buffers them as bytes in a FIFO.
- Serialises the bytes onto the UART TX line as 8N1 frames.
- Stalls the pipeline when the FIFO cannot take the requested bytes. Exposes drain status so the program can finish cleanly before halt.

Parameters:
- CLK_PER_BIT, 868: clock cycles per UART bit (100 MHz / 115200). Legal range is ≥2.
- LOG2_DEPTH, 6: FIFO depth is 2^LOG2_DEPTH bytes. Legal range is ≥2, so depth ≥4.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- out_valid  in  1  CPU output instruction in the issuing stage this cycle.
- out_word  in  1  1 = enqueue all 4 bytes of outw, LSB first; 0 = enqueue outw[7:0] only.
- outw  in  32  value read from the register file.
- out_stall  out  1  combinational; 1 = request not accepted this cycle, CPU must hold.
- txd  out  1  UART serial output, idle high.
- tx_busy  out  1  frame in progress (state != IDLE).
- tx_drained  out  1  FIFO empty and state IDLE.
- fifo_count  out  LOG2_DEPTH+1  bytes currently buffered.

Behaviour:
- Reset (rst=1 at a clock edge), effective the next cycle:
  - txd=1, state IDLE, FIFO pointers/count=0, bit and baud counters=0.
  - tx_busy=0, tx_drained=1, out_stall=0.
  - Reset mid-frame aborts the frame: txd goes high the next cycle and buffered bytes are discarded.
- Accept rule:
  - need = out_word ? 4 : 1; free = 2^LOG2_DEPTH − fifo_count.
  - out_stall = out_valid & (free < need). Free space released by a same-cycle pop is not counted.
  - Accept = out_valid & ~out_stall.
  - On accept, all `need` bytes are written in the same clock edge at wr_ptr, wr_ptr+1, … (mod depth), in order outw[7:0], [15:8], [23:16], [31:24].
  - A word is never partially enqueued.
- Count update: fifo_count_next = fifo_count + (accept ? need : 0) − (pop ? 1 : 0).
  - Simultaneous push and pop is legal. Pointers wrap modulo depth.
- Bytes pushed at edge t are poppable no earlier than the cycle after t. There is no bypass into the shifter.
- TX FSM, states IDLE, START, DATA, STOP:
  - IDLE: txd=1. If fifo_count>0, pop the head byte into the shift register, clear the baud counter, and go to START.
  - START: txd=0 for CLK_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: txd=shift[0] for CLK_PER_BIT cycles per bit. Shift right after each bit. After bit 7, go to STOP.
  - STOP: txd=1 for CLK_PER_BIT cycles. At the end, if fifo_count>0, pop and go directly to START (back-to-back, no idle gap); otherwise go to IDLE.
  - The baud counter counts 0..CLK_PER_BIT−1. A state or bit advance occurs on the cycle the counter equals CLK_PER_BIT−1.
- Frame timing:
  - Byte popped in IDLE at edge t: txd falls at t+1.
  - One frame = 10·CLK_PER_BIT cycles.
  - Back-to-back frames have zero extra cycles between stop and next start.
- Ordering: bytes leave in exact acceptance order, across word/byte mixes and pointer wrap.
- The FIFO never overflows: stall guarantees it. Pop never occurs when empty.
- txd is driven from a register, so the output is glitch-free.

Test Plan:
- Reset then idle (CLK_PER_BIT=4, LOG2_DEPTH=3), no requests → txd=1, tx_drained=1, fifo_count=0, out_stall=0 for 100 cycles.
- Single byte: out_valid=1, out_word=0, outw=0x000000A5 for one cycle → fifo_count=1 next cycle, 0 one cycle later. txd is then 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then 1 for 4 cycles. tx_drained returns to 1 after 40 cycles of frame.
- Word: outw=0x44332211, out_word=1 → fifo_count=4. Serial bytes 0x11,0x22,0x33,0x44 go out back-to-back, each 40 cycles, with no gap between stop and start.
- Full/stall with depth 8: push 2 words while TX blocked in first frame → count reaches 7 after 1 pop. A third word request gives out_stall=1 and holds. A byte request is accepted. Stall releases once free ≥4, and order is preserved.
- Wrap: stream 20 mixed byte/word requests through depth 8 → received byte stream equals the enqueue order exactly; fifo_count never exceeds 8.
- Reset mid-frame: assert rst during DATA bit 3 with 3 bytes buffered → next cycle txd=1, fifo_count=0, tx_busy=0. No further start bit appears until a new request.
